// File: rtl/cache_ram_pkg.sv
// Shared field widths and cache line layout for the cache_ram block.
package cache_ram_pkg;
    localparam int TAG_W      = 17;
    localparam int IDX_W      = 4;
    localparam int OFF_W      = 3;
    localparam int SETS       = 16;
    localparam int LINE_WORDS = 8;
    localparam int WORD_W     = 24;
    localparam int AGE_W      = 2;

    typedef logic [LINE_WORDS-1:0][WORD_W-1:0] words_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [AGE_W-1:0] age;
        words_t           words;
    } line_t;
endpackage

// File: rtl/cache_ram_store.sv
// Backing word store: synchronous single-word write, combinational whole-line read.
module cache_ram_store
    import cache_ram_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 24
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [AW-1:0]                  waddr,
    input  logic [DW-1:0]                  wdata,
    input  logic [AW-OFF_W-1:0]            line_idx,
    output logic [LINE_WORDS-1:0][DW-1:0]  line
);
    // Contents are never reset; they start at zero and persist across rst_n.
    logic [DW-1:0] mem [2**AW] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_rd
        assign line[gi] = mem[{line_idx, OFF_W'(gi)}];
    end
endmodule

// File: rtl/cache_ram.sv
// Write-through, no-write-allocate set-associative cache over a word RAM; one-cycle requests.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_ram
    import cache_ram_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 24,
    parameter int WAYS   = 4,
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              mode,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic              done,
    output logic [DATA_W-1:0] out,
    output logic              status,
    output logic              addBlock
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);
    localparam int              WAY_W   = $clog2(WAYS);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

    line_t cache [SETS][WAYS];

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic [RAM_AW-1:0] ram_addr;
    words_t            ram_line;

    assign tag      = address[TAG_W+IDX_W+OFF_W-1:IDX_W+OFF_W];
    assign idx      = address[IDX_W+OFF_W-1:OFF_W];
    assign off      = address[OFF_W-1:0];
    assign ram_addr = address[RAM_AW-1:0];

    // A clk edge during reset must not commit a write.
    cache_ram_store #(.AW(RAM_AW), .DW(DATA_W)) u_store (
        .clk      (clk),
        .we       (req && mode && rst_n),
        .waddr    (ram_addr),
        .wdata    (data),
        .line_idx (ram_addr[RAM_AW-1:OFF_W]),
        .line     (ram_line)
    );

    logic [WAYS-1:0]  hit_vec;
    logic [WAYS-1:0]  inv_vec;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] victim;
    logic [WAY_W-1:0] fill_way;
    logic [AGE_W-1:0] best_age;
    logic             hit;
    logic             has_inv;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
        assign hit_vec[gi] = cache[idx][gi].valid && (cache[idx][gi].tag == tag);
        assign inv_vec[gi] = !cache[idx][gi].valid;
    end

    // Downward scan leaves the lowest matching way; strict '>' keeps ties on the lowest way.
    always_comb begin
        hit_way  = '0;
        inv_way  = '0;
        victim   = '0;
        best_age = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (inv_vec[w]) inv_way = WAY_W'(w);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (cache[idx][w].age > best_age) begin
                best_age = cache[idx][w].age;
                victim   = WAY_W'(w);
            end
        end
    end

    assign hit      = |hit_vec;
    assign has_inv  = |inv_vec;
    assign fill_way = has_inv ? inv_way : victim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            out      <= '0;
            status   <= 1'b0;
            addBlock <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    cache[s][w].valid <= 1'b0;
                    cache[s][w].age   <= '0;
                end
            end
        end else begin
            done <= req;
            if (req) begin
                status   <= hit;
                addBlock <= 1'b0;
                if (mode) begin
                    if (hit) cache[idx][hit_way].words[off] <= data;
                end else begin
                    // Age every valid way first; the accessed/filled way is overridden to 0 below.
                    for (int w = 0; w < WAYS; w++) begin
                        if (cache[idx][w].valid && cache[idx][w].age != AGE_MAX)
                            cache[idx][w].age <= cache[idx][w].age + 1'b1;
                    end
                    if (hit) begin
                        out                     <= cache[idx][hit_way].words[off];
                        cache[idx][hit_way].age <= '0;
                    end else begin
                        out                  <= ram_line[off];
                        addBlock             <= has_inv;
                        cache[idx][fill_way] <= '{valid: 1'b1, tag: tag, age: '0, words: ram_line};
                    end
                end
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (req && !mode) begin
            if (hit) hit_count  <= hit_count + 16'd1;
            else     miss_count <= miss_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_ram.sv
// Directed scoreboard bench for cache_ram: stimulus pushes expectations, a monitor pops on done.
module tb_cache_ram;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        mode = 1'b0;
    logic [23:0] address = '0;
    logic [23:0] data = '0;
    logic        done;
    logic [23:0] out;
    logic        status;
    logic        addBlock;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    cache_ram dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .mode     (mode),
        .address  (address),
        .data     (data),
        .done     (done),
        .out      (out),
        .status   (status),
        .addBlock (addBlock)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        ab;
        logic [23:0] o;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    logic [23:0] last_out = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h required %h", nm, act, expv);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, ".status"}, {31'd0, status}, {31'd0, e.st});
                check({e.name, ".addBlock"}, {31'd0, addBlock}, {31'd0, e.ab});
                check({e.name, ".out"}, {8'd0, out}, {8'd0, e.o});
                $display("txn %s: status=%0d addBlock=%0d out=%h", e.name, status, addBlock, out);
            end
        end
    end

    // Reads expect o; writes expect out to hold the last read value.
    task automatic rq(input logic m, input logic [23:0] a, input logic [23:0] d,
                      input logic st, input logic ab, input logic [23:0] o, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        req = 1'b1; mode = m; address = a; data = d;
        e.st = st; e.ab = ab; e.o = m ? last_out : o; e.name = nm;
        sb.push_back(e);
        if (!m) last_out = o;
    endtask

    task automatic idle();
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        @(posedge clk);
        #1 rst_n = 1'b0;
        last_out = '0;
        @(negedge clk);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.out", {8'd0, out}, 32'd0);
        check("rst.status", {31'd0, status}, 32'd0);
        check("rst.addBlock", {31'd0, addBlock}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        // Cold miss, write-through hit, same-line hits.
        rq(0, 24'h000010, 0, 0, 1, 24'h000000, "r010_cold");
        rq(1, 24'h000010, 24'hABCDEF, 1, 0, 0, "w010_hit");
        rq(0, 24'h000010, 0, 1, 0, 24'hABCDEF, "r010_hit");
        rq(0, 24'h000011, 0, 1, 0, 24'h000000, "r011_line");
        rq(1, 24'h000011, 24'h123456, 1, 0, 0, "w011_hit");
        rq(0, 24'h000011, 0, 1, 0, 24'h123456, "r011_new");
        // Set 0: uncached write, four fills, LRU eviction of 0x000.
        rq(1, 24'h000000, 24'h000AAA, 0, 0, 0, "w000_miss");
        rq(0, 24'h000000, 0, 0, 1, 24'h000AAA, "r000_fill");
        rq(0, 24'h000080, 0, 0, 1, 24'h000000, "r080_fill");
        rq(0, 24'h000100, 0, 0, 1, 24'h000000, "r100_fill");
        rq(0, 24'h000180, 0, 0, 1, 24'h000000, "r180_fill");
        rq(0, 24'h000200, 0, 0, 0, 24'h000000, "r200_evict");
        rq(0, 24'h000000, 0, 0, 0, 24'h000AAA, "r000_evicted");
        rq(0, 24'h000180, 0, 1, 0, 24'h000000, "r180_still");

        // RAM survives reset; touching 0x000 moves the eviction to 0x080.
        do_reset();
        rq(0, 24'h000000, 0, 0, 1, 24'h000AAA, "p2_r000");
        rq(0, 24'h000080, 0, 0, 1, 24'h000000, "p2_r080");
        rq(0, 24'h000100, 0, 0, 1, 24'h000000, "p2_r100");
        rq(0, 24'h000180, 0, 0, 1, 24'h000000, "p2_r180");
        rq(0, 24'h000000, 0, 1, 0, 24'h000AAA, "p2_r000_hit");
        rq(0, 24'h000200, 0, 0, 0, 24'h000000, "p2_r200");
        rq(0, 24'h000000, 0, 1, 0, 24'h000AAA, "p2_r000_kept");
        rq(0, 24'h000080, 0, 0, 0, 24'h000000, "p2_r080_gone");
        idle();

        // Write issued while reset is held must be discarded.
        @(posedge clk);
        #1;
        rst_n = 1'b0; req = 1'b1; mode = 1'b1; address = 24'h0003F0; data = 24'h777777;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; req = 1'b0;
        last_out = '0;
        rq(1, 24'h000300, 24'h5A5A5A, 0, 0, 0, "w300_uncached");
        rq(0, 24'h000300, 0, 0, 1, 24'h5A5A5A, "r300_fill");
        rq(0, 24'h0003F0, 0, 0, 1, 24'h000000, "r3f0_discarded");
        idle();
        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/cache_ram.md
CACHE_RAM -- requirements
Module: cache_ram

Interface
REQ-001 Parameter ADDR_W, default 24, request address width in bits.
REQ-002 Parameter DATA_W, default 24, data word width in bits.
REQ-003 Parameter WAYS, default 4, blocks per set (power of two, at least 2).
REQ-004 Parameter RAM_AW, default 10, backing-RAM word-address width (1024 words).
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 req  in  1  request strobe, sampled at the clk edge.
REQ-009 mode  in  1  1 = write, 0 = read.
REQ-010 address  in  ADDR_W  word address.
REQ-011 data  in  DATA_W  write data.
REQ-012 done  out  1  one-cycle pulse marking the result of a request.
REQ-013 out  out  DATA_W  read data; holds its value when not updated.
REQ-014 status  out  1  1 = cache hit, 0 = miss.
REQ-015 addBlock  out  1  1 = the read miss filled a previously invalid way.

Function
REQ-016 Address split SHALL be: tag = address[23:7] (17 bits), set index = address[6:3] (16 sets), offset = address[2:0] (word within an 8-word line).
REQ-017 Backing RAM SHALL be 2^RAM_AW words indexed by address[RAM_AW-1:0]; line base = that index with offset bits zeroed.
REQ-018 Each way SHALL hold: valid bit, tag, 8 data words, and an age counter of log2(WAYS) bits.
REQ-019 Hit SHALL mean some way in the indexed set is valid with an equal tag.
REQ-020 Every req SHALL complete in exactly one cycle: done, out, status and addBlock are registered and update at the edge that samples req.
REQ-021 When req=0, done SHALL be 0 and out/status/addBlock SHALL hold.
REQ-022 Write SHALL always update RAM; on a hit it SHALL also update the matching cached word (write-through, no write-allocate). status = hit, addBlock = 0, out holds, ages unchanged.
REQ-023 Read hit SHALL return the cached word: status=1, addBlock=0.
REQ-024 Read miss with an invalid way in the set SHALL fill the lowest-numbered invalid way with the 8-word line from RAM, set valid and tag, return the RAM word, status=0, addBlock=1.
REQ-025 Read miss with a full set SHALL replace the way with the largest age (ties go to the lowest way), return the RAM word, status=0, addBlock=0.
REQ-026 On every read, the accessed or filled way's age SHALL become 0; other valid ways in the same set SHALL increment, saturating at WAYS-1; other sets SHALL be unchanged.
REQ-027 Read data SHALL reflect any write that completed in an earlier cycle.

Reset
REQ-028 While rst_n=0: all valid bits, ages, done, out, status and addBlock SHALL be 0; requests are ignored.
REQ-029 RAM contents SHALL NOT be reset; RAM SHALL initialise to 0 at time zero.
REQ-030 Reset asserted mid-request SHALL discard that request; the RAM write occurs only if a clk edge with rst_n=1 sampled it.

Configuration
REQ-031 With macro CACHE_STATS_EN defined, the block SHALL add outputs hit_count and miss_count (16 bits each, reset to 0, wrap-around), incremented on read hits and read misses respectively.
REQ-032 Without CACHE_STATS_EN, neither those ports nor their counters SHALL exist.

Structure
REQ-033 Shared package cache_ram_pkg SHALL hold the field widths (tag 17, index 4, offset 3), the set count (16) and the line typedef (valid, tag, age, 8 words).
REQ-034 The backing store SHALL be a sub-module, cache_ram_store (synchronous write, combinational line read).

Verification
REQ-035 Reset, then read 0x000010 -> status=0, addBlock=1, out=0.
REQ-036 Write 0x000010 data 0xABCDEF, then read 0x000010 -> status=1, out=0xABCDEF.
REQ-037 Read 0x000011 after REQ-036 -> status=1 (same line), out=RAM word at 0x011.
REQ-038 Read 0x000000, 0x000080, 0x000100, 0x000180 (set 0, four tags), then read 0x000200 -> fifth read status=0, addBlock=0; the 0x000000 line is evicted, so a re-read of 0x000000 gives status=0.
REQ-039 Set 0 full; re-read 0x000000 before the fifth tag -> 0x000080 is evicted instead, and 0x000000 then hits.
REQ-040 Write to an uncached address 0x000300 -> status=0; a later read gives status=0, addBlock=1, out=written value.
